// File: rtl/clahe_clip_cdf_builder.sv
// CLAHE per-tile clip / redistribute / CDF / LUT builder, run once per frame over every tile.
// Optional macro CLAHE_RESIDUAL_EN spreads the sub-256 excess remainder as +1 on the lowest bins.
module clahe_clip_cdf_builder #(
  parameter int TILE_NUM_BITS = 6,
  parameter int TILE_PIXELS   = 14400,
  parameter int CDF_SCALE     = 1161
) (
  input  logic                     pclk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              clip_limit,
  output logic [TILE_NUM_BITS-1:0] hist_rd_tile_idx,
  output logic [7:0]               hist_rd_addr,
  input  logic [15:0]              hist_rd_data,
  output logic [TILE_NUM_BITS-1:0] lut_wr_tile_idx,
  output logic [7:0]               lut_wr_addr,
  output logic [7:0]               lut_wr_data,
  output logic                     lut_wr_en,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  if (CDF_SCALE != (255 * 65536 + TILE_PIXELS / 2) / TILE_PIXELS) begin : g_bad_scale
    $error("CDF_SCALE does not match TILE_PIXELS");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLIP, S_CALC, S_CDF, S_NEXT, S_DONE} state_t;

  state_t      state;
  logic [8:0]  cnt;
  logic [15:0] clip_lat;
  logic [16:0] excess;
  logic [8:0]  per_bin;
  logic [17:0] cdf;
`ifdef CLAHE_RESIDUAL_EN
  logic [7:0]  residual;
`endif

  function automatic logic [16:0] sat_add17(input logic [16:0] a, input logic [15:0] b);
    logic [17:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[17] ? 17'h1FFFF : s[16:0];
  endfunction

  function automatic logic [17:0] sat_add18(input logic [17:0] a, input logic [17:0] b);
    logic [18:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[18] ? 18'h3FFFF : s[17:0];
  endfunction

  function automatic logic [7:0] lut_map(input logic [17:0] c);
    logic [33:0] p;
    p = (34'(c) * 34'(CDF_SCALE)) >> 16;
    return (p > 34'd255) ? 8'hFF : 8'(p);
  endfunction

  // Stage p1: read data returns one cycle after the address; bin index trails cnt by one
  logic [15:0] clip_p1;
  logic [7:0]  bin_p1;
  logic        res_p1;
  logic        vld_p1;
  logic [17:0] v_p1;
  logic [17:0] cdf_nxt_p1;

  assign clip_p1 = (hist_rd_data < clip_lat) ? hist_rd_data : clip_lat;
  assign bin_p1  = cnt[7:0] - 8'd1;
`ifdef CLAHE_RESIDUAL_EN
  assign res_p1  = (bin_p1 < residual);
`else
  assign res_p1  = 1'b0;
`endif
  assign vld_p1     = (cnt != 9'd0) && (cnt != 9'd257);
  assign v_p1       = 18'(clip_p1) + 18'(per_bin) + 18'(res_p1);
  assign cdf_nxt_p1 = sat_add18(cdf, v_p1);

  // Stage p2: registered LUT write, two cycles after the read address
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      clip_lat         <= '0;
      excess           <= '0;
      per_bin          <= '0;
      cdf              <= '0;
`ifdef CLAHE_RESIDUAL_EN
      residual         <= '0;
`endif
      hist_rd_tile_idx <= '0;
      hist_rd_addr     <= '0;
      lut_wr_tile_idx  <= '0;
      lut_wr_addr      <= '0;
      lut_wr_data      <= '0;
      lut_wr_en        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      overrun   <= start && (state != S_IDLE);
      done      <= 1'b0;
      lut_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state            <= S_CLIP;
            busy             <= 1'b1;
            clip_lat         <= clip_limit;
            cnt              <= '0;
            excess           <= '0;
            cdf              <= '0;
            hist_rd_tile_idx <= '0;
            hist_rd_addr     <= '0;
          end
        end
        S_CLIP: begin
          if (cnt != 9'd0) excess <= sat_add17(excess, hist_rd_data - clip_p1);
          if (cnt < 9'd255) hist_rd_addr <= hist_rd_addr + 8'd1;
          if (cnt == 9'd256) begin
            state <= S_CALC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        S_CALC: begin
          per_bin      <= excess[16:8];
`ifdef CLAHE_RESIDUAL_EN
          residual     <= excess[7:0];
`endif
          hist_rd_addr <= '0;
          cnt          <= '0;
          state        <= S_CDF;
        end
        S_CDF: begin
          if (vld_p1) begin
            cdf             <= cdf_nxt_p1;
            lut_wr_en       <= 1'b1;
            lut_wr_addr     <= bin_p1;
            lut_wr_data     <= lut_map(cdf_nxt_p1);
            lut_wr_tile_idx <= hist_rd_tile_idx;
          end
          if (cnt < 9'd255) hist_rd_addr <= hist_rd_addr + 8'd1;
          if (cnt == 9'd257) begin
            state <= S_NEXT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        S_NEXT: begin
          excess <= '0;
          cdf    <= '0;
          if (hist_rd_tile_idx == '1) begin
            state <= S_DONE;
          end else begin
            hist_rd_tile_idx <= hist_rd_tile_idx + 1'b1;
            hist_rd_addr     <= '0;
            state            <= S_CLIP;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
